axichacha_block_sequencer: RTL
==============================

Name: axichacha_block_sequencer

Overview:
Control FSM that drives the ChaCha20 keystream core inside the AXI-stream ChaCha DMA.
- Waits for the input buffer to hold NUMBER_OF_BLOCKS x 512 bits.
- Issues one core start per 512-bit block, with the correct block index and block counter.
- Captures each result into the output buffer, then raises data_valid (CONTROL register bit 1) until the output stream drains.
- Sits between the AXI4-Lite register file, the AXIS input/output buffers and the ChaCha core.

Parameters:
NUMBER_OF_BLOCKS, 16, number of 512-bit blocks per buffer fill (>=1).
BLK_W, $clog2(NUMBER_OF_BLOCKS) (min 1), width of the block index.

Ports:
aclk  in  1  clock (all AXI/AXIS interfaces share it).
areset  in  1  asynchronous, active-high reset.
ctrl_resetn  in  1  CONTROL register bit 0; 0 = soft reset / disabled.
key  in  256  key from the register file.
iv  in  96  nonce from the register file.
ctr_init  in  32  initial block counter.
in_full  in  1  input buffer holds a full payload.
in_consume  out  1  one-cycle pulse; input buffer may refill.
core_start  out  1  one-cycle start pulse to the core.
core_key  out  256  latched key.
core_nonce  out  96  latched nonce.
core_ctr  out  32  block counter for the current block.
blk_sel  out  BLK_W  buffer slot for the current block.
core_done  in  1  core result ready (single-cycle pulse).
out_wr  out  1  one-cycle pulse; output buffer captures the core result into slot blk_sel.
out_drained  in  1  pulse when the last output beat has been accepted.
data_valid  out  1  output payload ready (drives CONTROL bit 1).
busy  out  1  high in START/BUSY/WRITE.
ctr_wrapped  out  1  sticky; the counter wrapped 0xFFFFFFFF -> 0.

Behaviour:
- areset high: every output is 0, core_key/core_nonce/core_ctr are 0, state IDLE. Reset takes effect immediately (asynchronous) and releases at the next aclk edge.
- States: IDLE, WAIT_IN, START, BUSY, WRITE, VALID. All outputs are registered.
- IDLE: on ctrl_resetn=1, latch key->core_key, iv->core_nonce, ctr_init->core_ctr, clear ctr_wrapped, go to WAIT_IN.
  - key, iv and ctr_init are sampled only on that transition; register writes during operation are ignored until the next soft reset.
- ctrl_resetn=0 in any state: go to IDLE next cycle and clear data_valid, busy, blk_sel and all pulses. A core_done arriving after this is ignored.
- WAIT_IN: in_full=1 -> START, blk_sel=0.
- START: core_start=1 for exactly one cycle -> BUSY.
- BUSY: hold blk_sel and core_ctr; on core_done -> WRITE. Core latency is unbounded; there is no timeout.
- WRITE: out_wr=1 for one cycle.
  - core_ctr increments mod 2^32. On increment from 0xFFFFFFFF set ctr_wrapped (the result is 0; the counter keeps running).
  - If blk_sel == NUMBER_OF_BLOCKS-1: in_consume=1 same cycle, data_valid<=1, go to VALID.
  - Otherwise blk_sel++ and go to START.
- VALID: data_valid held at 1. On out_drained, data_valid<=0 and go to WAIT_IN.
  - If in_full is already 1 at that point, START follows after exactly one WAIT_IN cycle.
- core_ctr persists across payloads; it is not reloaded per payload. The counter for payload p, block b is ctr_init + p*NUMBER_OF_BLOCKS + b.
- Ignored inputs:
  - core_done outside BUSY.
  - in_full outside WAIT_IN.
  - out_drained outside VALID.
- Latency:
  - in_full to core_start: 2 cycles (WAIT_IN, then START).
  - Per block: 1 (START) + core latency + 1 (WRITE).
- NUMBER_OF_BLOCKS=1: blk_sel stays 0; WRITE goes directly to VALID.

Decomposition:
- Shared package axichacha_pkg holds:
  - state encodings;
  - CONTROL_RESETN=0 and CONTROL_DATA_VALID=1 bit positions;
  - KEY_WORDS=8, IV_WORDS=3;
  - BLOCK_BITS=512.
- The register file and this block both import axichacha_pkg.
- One natural sub-module, axichacha_blk_counter: the 32-bit counter with load, increment and sticky-wrap logic.
- The FSM stays in axichacha_block_sequencer.

Test Plan:
Bench setup for all cases: NUMBER_OF_BLOCKS=4, core stub with core_done 3 cycles after core_start.
1. Power-up reset (areset 1 for 2 cycles) -> all outputs 0. Release with ctrl_resetn=0 -> state stays IDLE, busy=0.
2. ctrl_resetn=1, ctr_init=5, in_full pulse -> 4 core_start pulses with (blk_sel, core_ctr) = (0,5), (1,6), (2,7), (3,8). Each is followed by out_wr 4 cycles later. in_consume and data_valid rise on the 4th out_wr cycle.
3. Two back-to-back payloads, in_full held and out_drained pulsed -> second payload uses core_ctr 9..12. Exactly one WAIT_IN cycle between out_drained and core_start.
4. ctr_init=0xFFFFFFFE -> counters FFFFFFFE, FFFFFFFF, 0, 1. ctr_wrapped rises on the WRITE after 0xFFFFFFFF and stays 1 until the next soft reset.
5. Drop ctrl_resetn during BUSY on block 2 -> IDLE next cycle, no out_wr, the late core_done is ignored, data_valid=0. Re-enable relatches key/iv and reloads ctr_init.
6. Change key and iv registers mid-payload -> core_key and core_nonce are unchanged until the next ctrl_resetn 0->1. A spurious core_done in WAIT_IN produces no out_wr.

Source files
------------

// File: rtl/axichacha_pkg.sv
// Shared definitions for the AXI-stream ChaCha DMA: CONTROL bit positions,
// key/nonce geometry and the block sequencer state encoding.
package axichacha_pkg;

    localparam int unsigned CONTROL_RESETN     = 0;
    localparam int unsigned CONTROL_DATA_VALID = 1;

    localparam int unsigned KEY_WORDS  = 8;
    localparam int unsigned IV_WORDS   = 3;
    localparam int unsigned BLOCK_BITS = 512;

    localparam int unsigned KEY_W = KEY_WORDS * 32;
    localparam int unsigned IV_W  = IV_WORDS * 32;
    localparam int unsigned CTR_W = 32;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t StIdle   = 3'd0;
    localparam seq_state_t StWaitIn = 3'd1;
    localparam seq_state_t StStart  = 3'd2;
    localparam seq_state_t StBusy   = 3'd3;
    localparam seq_state_t StWrite  = 3'd4;
    localparam seq_state_t StValid  = 3'd5;

    // Slot index width; a single-block buffer still gets a 1-bit index.
    function automatic int unsigned blk_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axichacha_blk_counter.sv
// 32-bit ChaCha block counter: loadable, free-running increment, sticky wrap flag.
module axichacha_blk_counter
    import axichacha_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CTR_W-1:0] load_val,
    input  logic             inc,
    output logic [CTR_W-1:0] count,
    output logic             wrapped
);

    logic [CTR_W-1:0] count_q;
    logic             wrapped_q;

    // Load wins over increment; the wrap flag survives until the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            wrapped_q <= 1'b0;
        end else if (load) begin
            count_q   <= load_val;
            wrapped_q <= 1'b0;
        end else if (inc) begin
            count_q <= count_q + 1'b1;
            if (count_q == '1) begin
                wrapped_q <= 1'b1;
            end
        end
    end

    assign count   = count_q;
    assign wrapped = wrapped_q;

endmodule

// File: rtl/axichacha_block_sequencer.sv
// Control FSM feeding the ChaCha20 core one 512-bit block at a time and
// handing finished payloads to the output stream.
module axichacha_block_sequencer
    import axichacha_pkg::*;
#(
    parameter int unsigned NUMBER_OF_BLOCKS = 16,
    parameter int unsigned BLK_W            = blk_width(NUMBER_OF_BLOCKS)
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             ctrl_resetn,
    input  logic [KEY_W-1:0] key,
    input  logic [IV_W-1:0]  iv,
    input  logic [CTR_W-1:0] ctr_init,
    input  logic             in_full,
    output logic             in_consume,
    output logic             core_start,
    output logic [KEY_W-1:0] core_key,
    output logic [IV_W-1:0]  core_nonce,
    output logic [CTR_W-1:0] core_ctr,
    output logic [BLK_W-1:0] blk_sel,
    input  logic             core_done,
    output logic             out_wr,
    input  logic             out_drained,
    output logic             data_valid,
    output logic             busy,
    output logic             ctr_wrapped
);

    localparam logic [BLK_W-1:0] LastBlk = BLK_W'(NUMBER_OF_BLOCKS - 1);

    seq_state_t       state_q, state_d;
    logic [BLK_W-1:0] blk_sel_q, blk_sel_d;
    logic [KEY_W-1:0] key_q;
    logic [IV_W-1:0]  nonce_q;
    logic             core_start_q, out_wr_q, in_consume_q, data_valid_q, busy_q;
    logic             load, inc, last_d;

    // Next state and buffer slot; a soft reset overrides everything.
    always_comb begin
        state_d   = state_q;
        blk_sel_d = blk_sel_q;
        if (!ctrl_resetn) begin
            state_d   = StIdle;
            blk_sel_d = '0;
        end else begin
            case (state_q)
                StIdle:   state_d = StWaitIn;
                StWaitIn: begin
                    if (in_full) begin
                        state_d   = StStart;
                        blk_sel_d = '0;
                    end
                end
                StStart:  state_d = StBusy;
                StBusy:   if (core_done) state_d = StWrite;
                StWrite: begin
                    if (blk_sel_q == LastBlk) begin
                        state_d = StValid;
                    end else begin
                        state_d   = StStart;
                        blk_sel_d = blk_sel_q + 1'b1;
                    end
                end
                StValid:  if (out_drained) state_d = StWaitIn;
                default:  state_d = StIdle;
            endcase
        end
    end

    assign load   = (state_q == StIdle) && ctrl_resetn;
    assign inc    = (state_q == StWrite) && ctrl_resetn;
    assign last_d = (state_d == StWrite) && (blk_sel_d == LastBlk);

    // State plus outputs registered from the next state so they align with it.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= StIdle;
            blk_sel_q    <= '0;
            key_q        <= '0;
            nonce_q      <= '0;
            core_start_q <= 1'b0;
            out_wr_q     <= 1'b0;
            in_consume_q <= 1'b0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            blk_sel_q    <= blk_sel_d;
            core_start_q <= (state_d == StStart);
            out_wr_q     <= (state_d == StWrite);
            in_consume_q <= last_d;
            // Payload is flagged valid from the final capture onwards.
            data_valid_q <= (state_d == StValid) || last_d;
            busy_q       <= (state_d == StStart) || (state_d == StBusy) ||
                            (state_d == StWrite);
            if (load) begin
                key_q   <= key;
                nonce_q <= iv;
            end
        end
    end

    axichacha_blk_counter u_blk_counter (
        .clk      (aclk),
        .rst      (areset),
        .load     (load),
        .load_val (ctr_init),
        .inc      (inc),
        .count    (core_ctr),
        .wrapped  (ctr_wrapped)
    );

    assign blk_sel    = blk_sel_q;
    assign core_key   = key_q;
    assign core_nonce = nonce_q;
    assign core_start = core_start_q;
    assign out_wr     = out_wr_q;
    assign in_consume = in_consume_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;

endmodule
